spmv_mem_model: RTL and testbench



---
 rtl/spmv_mem_pkg.sv | 21 ++
 rtl/spmv_mem_rsp_fifo.sv | 49 ++++
 rtl/spmv_mem_model.sv | 191 +++++++++++++++++++
 tb/tb_spmv_mem_model.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spmv_mem_pkg.sv
// Shared constants and types for the SpMV memory model and its response FIFO.
package spmv_mem_pkg;

  localparam int unsigned DEF_LATENCY    = 8;
  localparam int unsigned DEF_FIFO_DEPTH = 16;
  localparam int unsigned DEF_TAG_W      = 3;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic [DEF_TAG_W-1:0] tag;
    logic [63:0]          q;
  } rsp_entry_t;

  // Right-shifting Galois LFSR, taps x^16+x^14+x^13+x^11+1.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/spmv_mem_rsp_fifo.sv
// Per-channel response FIFO; the caller's credit scheme guarantees it never overflows.
module spmv_mem_rsp_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 67
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [WIDTH-1:0]        wdata,
  input  logic                    pop,
  output logic [WIDTH-1:0]        rdata,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] store_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) store_q[wr_ptr_q] <= wdata;
  end

  assign rdata = store_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/spmv_mem_model.sv
// Multi-channel cycle-accurate main-memory model: latency pipes, response FIFOs, credit stall.
// Optional random request stall is enabled with SPMV_MEM_MODEL_RANDOM_STALL_EN.
module spmv_mem_model
  import spmv_mem_pkg::*;
#(
  parameter int unsigned CHANNELS   = 1,
  parameter int unsigned LATENCY    = DEF_LATENCY,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned TAG_W      = DEF_TAG_W,
  parameter int unsigned ADDR_W     = 48,
  parameter int unsigned MEM_WORDS  = 1000000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CHANNELS-1:0]        req_ld,
  input  logic [CHANNELS-1:0]        req_st,
  input  logic [CHANNELS*ADDR_W-1:0] req_addr,
  input  logic [CHANNELS*64-1:0]     req_d_or_tag,
  output logic [CHANNELS-1:0]        req_stall,
  output logic [CHANNELS-1:0]        rsp_push,
  output logic [CHANNELS*TAG_W-1:0]  rsp_tag,
  output logic [CHANNELS*64-1:0]     rsp_q,
  input  logic [CHANNELS-1:0]        rsp_stall,
  output logic                       err
);

  localparam int unsigned ENT_W  = TAG_W + 64;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned WIDX_W = ADDR_W - 3;
  localparam int unsigned IDX_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [WIDX_W-1:0] MEM_LIMIT  = WIDX_W'(MEM_WORDS);
  localparam logic [CNT_W-1:0]  CREDIT_MAX = CNT_W'(FIFO_DEPTH);

  logic [63:0]         mem_q [MEM_WORDS];

  logic [WIDX_W-1:0]   widx     [CHANNELS];
  logic [ENT_W-1:0]    ld_ent   [CHANNELS];
  logic [CHANNELS-1:0] in_range;
  logic [CHANNELS-1:0] acc_ld;
  logic [CHANNELS-1:0] acc_st;
  logic [CHANNELS-1:0] wr_en;
  logic                unused_addr_lsb;

  logic                err_q, err_d;
  logic [CNT_W-1:0]    out_q [CHANNELS];
  logic [CNT_W-1:0]    out_d [CHANNELS];
  logic [CHANNELS-1:0] credit_stall;

  logic [CHANNELS-1:0] pipe_vld_q [LATENCY];
  logic [CHANNELS-1:0] pipe_vld_d [LATENCY];
  logic [ENT_W-1:0]    pipe_ent_q [LATENCY][CHANNELS];
  logic [ENT_W-1:0]    pipe_ent_d [LATENCY][CHANNELS];

  logic [ENT_W-1:0]    fifo_rdata [CHANNELS];
  logic [CNT_W-1:0]    fifo_cnt   [CHANNELS];
  logic [CHANNELS-1:0] fifo_pop;

  logic [CHANNELS-1:0] rsp_push_q, rsp_push_d;
  logic [ENT_W-1:0]    rsp_ent_q [CHANNELS];
  logic [ENT_W-1:0]    rsp_ent_d [CHANNELS];

  // Request decode: a simultaneous ld+st is a load; out-of-range stores never reach the array.
  always_comb begin
    err_d           = err_q;
    unused_addr_lsb = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      widx[c]         = req_addr[c*ADDR_W+3 +: WIDX_W];
      unused_addr_lsb = unused_addr_lsb ^ (^req_addr[c*ADDR_W +: 3]);
      in_range[c]     = widx[c] < MEM_LIMIT;
      acc_ld[c]       = req_ld[c] & ~req_stall[c];
      acc_st[c]       = req_st[c] & ~req_ld[c] & ~req_stall[c];
      wr_en[c]        = acc_st[c] & in_range[c];
      ld_ent[c]       = {req_d_or_tag[c*64 +: TAG_W],
                         in_range[c] ? mem_q[widx[c][IDX_W-1:0]] : 64'd0};
      if ((acc_ld[c] & req_st[c]) | ((acc_ld[c] | acc_st[c]) & ~in_range[c])) begin
        err_d = 1'b1;
      end
      out_d[c]        = out_q[c] + CNT_W'(acc_ld[c]) - CNT_W'(rsp_push_q[c]);
      credit_stall[c] = out_q[c] >= CREDIT_MAX;
    end
  end

  // Ascending channel order makes the highest channel's store win on a same-word collision.
  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (wr_en[c]) mem_q[widx[c][IDX_W-1:0]] <= req_d_or_tag[c*64 +: 64];
    end
  end

  always_comb begin
    pipe_vld_d[0] = acc_ld;
    for (int c = 0; c < CHANNELS; c++) begin
      pipe_ent_d[0][c] = ld_ent[c];
    end
    for (int s = 1; s < LATENCY; s++) begin
      pipe_vld_d[s] = pipe_vld_q[s-1];
      for (int c = 0; c < CHANNELS; c++) begin
        pipe_ent_d[s][c] = pipe_ent_q[s-1][c];
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    spmv_mem_rsp_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENT_W)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (pipe_vld_q[LATENCY-1][g]),
      .wdata (pipe_ent_q[LATENCY-1][g]),
      .pop   (fifo_pop[g]),
      .rdata (fifo_rdata[g]),
      .count (fifo_cnt[g])
    );
  end

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      fifo_pop[c]   = (fifo_cnt[c] != '0) & ~rsp_stall[c];
      rsp_push_d[c] = fifo_pop[c];
      rsp_ent_d[c]  = fifo_pop[c] ? fifo_rdata[c] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q      <= 1'b0;
      rsp_push_q <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        out_q[c]     <= '0;
        rsp_ent_q[c] <= '0;
      end
      for (int s = 0; s < LATENCY; s++) begin
        pipe_vld_q[s] <= '0;
        for (int c = 0; c < CHANNELS; c++) begin
          pipe_ent_q[s][c] <= '0;
        end
      end
    end else begin
      err_q      <= err_d;
      rsp_push_q <= rsp_push_d;
      for (int c = 0; c < CHANNELS; c++) begin
        out_q[c]     <= out_d[c];
        rsp_ent_q[c] <= rsp_ent_d[c];
      end
      for (int s = 0; s < LATENCY; s++) begin
        pipe_vld_q[s] <= pipe_vld_d[s];
        for (int c = 0; c < CHANNELS; c++) begin
          pipe_ent_q[s][c] <= pipe_ent_d[s][c];
        end
      end
    end
  end

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      rsp_tag[c*TAG_W +: TAG_W] = rsp_ent_q[c][ENT_W-1 -: TAG_W];
      rsp_q[c*64 +: 64]         = rsp_ent_q[c][63:0];
    end
  end

  assign rsp_push = rsp_push_q;
  assign err      = err_q;

`ifdef SPMV_MEM_MODEL_RANDOM_STALL_EN
  logic [15:0]         lfsr_q [CHANNELS];
  logic [15:0]         lfsr_d [CHANNELS];
  logic [CHANNELS-1:0] rand_stall;

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      lfsr_d[c]     = lfsr_next(lfsr_q[c]);
      rand_stall[c] = (lfsr_q[c][2:0] == 3'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) lfsr_q[c] <= LFSR_SEED + 16'(c);
    end else begin
      for (int c = 0; c < CHANNELS; c++) lfsr_q[c] <= lfsr_d[c];
    end
  end

  assign req_stall = credit_stall | rand_stall;
`else
  assign req_stall = credit_stall;
`endif

endmodule

// File: tb/tb_spmv_mem_model.sv
// Directed self-checking bench for spmv_mem_model (4 channels, small array).
module tb_spmv_mem_model;

  localparam int CH = 4;
  localparam int AW = 48;
  localparam int TW = 3;
  localparam int MW = 1024;

  logic              clk;
  logic              rst_n;
  logic [CH-1:0]     req_ld;
  logic [CH-1:0]     req_st;
  logic [CH*AW-1:0]  req_addr;
  logic [CH*64-1:0]  req_d_or_tag;
  logic [CH-1:0]     req_stall;
  logic [CH-1:0]     rsp_push;
  logic [CH*TW-1:0]  rsp_tag;
  logic [CH*64-1:0]  rsp_q;
  logic [CH-1:0]     rsp_stall;
  logic              err;

  spmv_mem_model #(
    .CHANNELS   (CH),
    .LATENCY    (8),
    .FIFO_DEPTH (16),
    .TAG_W      (TW),
    .ADDR_W     (AW),
    .MEM_WORDS  (MW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_ld       (req_ld),
    .req_st       (req_st),
    .req_addr     (req_addr),
    .req_d_or_tag (req_d_or_tag),
    .req_stall    (req_stall),
    .rsp_push     (rsp_push),
    .rsp_tag      (rsp_tag),
    .rsp_q        (rsp_q),
    .rsp_stall    (rsp_stall),
    .err          (err)
  );

  typedef struct packed {
    logic [1:0]  ch;
    logic [2:0]  tag;
    logic [63:0] q;
    logic [31:0] cyc;
  } rsp_t;

  rsp_t log_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   early, n_acc, first_stall, acc_cyc, rel_cyc;
  rsp_t e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    for (int c = 0; c < CH; c++) begin
      if (rsp_push[c]) log_q.push_back({2'(c), rsp_tag[c*TW +: TW], rsp_q[c*64 +: 64], cyc});
    end
  end

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic set_req(input int c, input logic ld, input logic st,
                         input logic [AW-1:0] addr, input logic [63:0] d);
    req_ld[c] = ld;
    req_st[c] = st;
    req_addr[c*AW +: AW] = addr;
    req_d_or_tag[c*64 +: 64] = d;
  endtask

  task automatic clr_req();
    req_ld = '0;
    req_st = '0;
    req_addr = '0;
    req_d_or_tag = '0;
  endtask

  task automatic store(input int c, input logic [AW-1:0] addr, input logic [63:0] d);
    set_req(c, 1'b0, 1'b1, addr, d);
    @(negedge clk);
    clr_req();
  endtask

  task automatic wait_log(input int n, input int limit);
    int k;
    k = 0;
    while (log_q.size() < n && k < limit) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic get_rsp(input int i, output rsp_t r);
    if (log_q.size() > i) r = log_q[i];
    else r = '1;
  endtask

  // Single load on one channel; returns the first response seen (all-ones if none).
  task automatic load_wait(input int c, input logic [AW-1:0] addr, input logic [63:0] tag,
                           output rsp_t r);
    log_q.delete();
    set_req(c, 1'b1, 1'b0, addr, tag);
    @(negedge clk);
    clr_req();
    wait_log(1, 30);
    get_rsp(0, r);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    clr_req();
    rsp_stall = '0;
    repeat (2) @(negedge clk);
    check("reset_rsp_push", 64'(rsp_push), 64'h0);
    check("reset_rsp_tag", 64'(rsp_tag), 64'h0);
    check("reset_rsp_q_lo", rsp_q[63:0], 64'h0);
    check("reset_req_stall", 64'(req_stall), 64'h0);
    check("reset_err", 64'(err), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 20; i++) store(0, 48'((100 + i) * 8), 64'h1000 + 64'(i));
    store(0, 48'd40, 64'h4014000000000000);
    store(0, 48'd88, 64'h55);

    // Latency: accept at edge 0, response visible only after edge 9
    log_q.delete();
    set_req(0, 1'b1, 1'b0, 48'd40, 64'd3);
    @(negedge clk);
    clr_req();
    early = 0;
    for (int i = 0; i < 9; i++) begin
      if (rsp_push[0]) early++;
      @(negedge clk);
    end
    check("lat_no_early_push", 64'(early), 64'h0);
    check("lat_push", 64'(rsp_push[0]), 64'h1);
    check("lat_tag", 64'(rsp_tag[2:0]), 64'h3);
    check("lat_q", rsp_q[63:0], 64'h4014000000000000);
    @(negedge clk);
    check("lat_push_drop", 64'(rsp_push[0]), 64'h0);
    check("lat_q_zero", rsp_q[63:0], 64'h0);
    check("lat_tag_zero", 64'(rsp_tag[2:0]), 64'h0);

    // Store then load on the next edge
    store(0, 48'd80, 64'hDEAD);
    load_wait(0, 48'd80, 64'd5, e);
    check("st_ld_q", e.q, 64'hDEAD);
    check("st_ld_tag", 64'(e.tag), 64'h5);

    // Same-edge load (ch0) and store (ch1) to one word: load sees old data
    log_q.delete();
    set_req(0, 1'b1, 1'b0, 48'd80, 64'd6);
    set_req(1, 1'b0, 1'b1, 48'd80, 64'hBEEF);
    @(negedge clk);
    clr_req();
    wait_log(1, 30);
    get_rsp(0, e);
    check("same_edge_old_q", e.q, 64'hDEAD);
    load_wait(2, 48'd80, 64'd1, e);
    check("same_edge_new_q", e.q, 64'hBEEF);
    check("same_edge_new_ch", 64'(e.ch), 64'h2);

    // Two stores to one word on the same edge: channel 3 beats channel 1
    set_req(1, 1'b0, 1'b1, 48'd80, 64'h111);
    set_req(3, 1'b0, 1'b1, 48'd80, 64'h333);
    @(negedge clk);
    clr_req();
    load_wait(0, 48'd80, 64'd2, e);
    check("st_st_high_wins", e.q, 64'h333);
    check("no_err_yet", 64'(err), 64'h0);

    // Multi-channel: only channel 2 is backpressured
    log_q.delete();
    rsp_stall = 4'b0100;
    for (int c = 0; c < CH; c++) set_req(c, 1'b1, 1'b0, 48'((100 + c) * 8), 64'(c + 1));
    acc_cyc = cyc + 1;
    @(negedge clk);
    clr_req();
    repeat (15) @(negedge clk);
    check("mc_count_stalled", 64'(log_q.size()), 64'd3);
    get_rsp(0, e);
    check("mc_r0_ch", 64'(e.ch), 64'h0);
    check("mc_r0_q", e.q, 64'h1000);
    check("mc_r0_cyc", 64'(e.cyc), 64'(acc_cyc + 9));
    get_rsp(1, e);
    check("mc_r1_ch", 64'(e.ch), 64'h1);
    check("mc_r1_q", e.q, 64'h1001);
    check("mc_r1_cyc", 64'(e.cyc), 64'(acc_cyc + 9));
    get_rsp(2, e);
    check("mc_r3_ch", 64'(e.ch), 64'h3);
    check("mc_r3_q", e.q, 64'h1003);
    check("mc_r3_tag", 64'(e.tag), 64'h4);
    check("mc_r3_cyc", 64'(e.cyc), 64'(acc_cyc + 9));
    rsp_stall = '0;
    rel_cyc = cyc + 1;
    @(negedge clk);
    wait_log(4, 10);
    check("mc_count_drained", 64'(log_q.size()), 64'd4);
    get_rsp(3, e);
    check("mc_r2_ch", 64'(e.ch), 64'h2);
    check("mc_r2_q", e.q, 64'h1002);
    check("mc_r2_tag", 64'(e.tag), 64'h3);
    check("mc_r2_cyc", 64'(e.cyc), 64'(rel_cyc));

    // Backpressure: 20 loads against a stalled consumer, 16 credits
    log_q.delete();
    rsp_stall[0] = 1'b1;
    n_acc = 0;
    first_stall = -1;
    for (int k = 0; k < 25; k++) begin
      if (n_acc < 20) begin
        set_req(0, 1'b1, 1'b0, 48'((100 + n_acc) * 8), 64'(n_acc % 8));
        if (!req_stall[0]) n_acc++;
        else if (first_stall < 0) first_stall = n_acc;
      end
      @(negedge clk);
    end
    check("bp_accepted_before_release", 64'(n_acc), 64'd16);
    check("bp_stall_after_16", 64'(first_stall), 64'd16);
    check("bp_req_stall_high", 64'(req_stall[0]), 64'h1);
    check("bp_no_rsp_while_stalled", 64'(log_q.size()), 64'd0);
    rsp_stall[0] = 1'b0;
    for (int k = 0; k < 150 && (n_acc < 20 || log_q.size() < 20); k++) begin
      if (n_acc < 20) begin
        set_req(0, 1'b1, 1'b0, 48'((100 + n_acc) * 8), 64'(n_acc % 8));
        if (!req_stall[0]) n_acc++;
      end else begin
        clr_req();
      end
      @(negedge clk);
    end
    clr_req();
    repeat (5) @(negedge clk);
    check("bp_total_accepted", 64'(n_acc), 64'd20);
    check("bp_total_rsp", 64'(log_q.size()), 64'd20);
    for (int i = 0; i < 20; i++) begin
      get_rsp(i, e);
      check($sformatf("bp_q_%0d", i), e.q, 64'h1000 + 64'(i));
      check($sformatf("bp_tag_%0d", i), 64'(e.tag), 64'(i % 8));
    end
    check("bp_req_stall_low", 64'(req_stall[0]), 64'h0);

    // Reset with loads in flight: nothing comes out afterwards
    log_q.delete();
    for (int i = 0; i < 5; i++) begin
      set_req(0, 1'b1, 1'b0, 48'((100 + i) * 8), 64'(i));
      @(negedge clk);
    end
    clr_req();
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_push", 64'(rsp_push), 64'h0);
    check("rst_mid_stall", 64'(req_stall), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    log_q.delete();
    repeat (20) @(negedge clk);
    check("rst_no_late_rsp", 64'(log_q.size()), 64'd0);
    check("rst_req_stall", 64'(req_stall), 64'h0);
    load_wait(0, 48'd40, 64'd7, e);
    check("rst_mem_preserved", e.q, 64'h4014000000000000);
    check("rst_mem_tag", 64'(e.tag), 64'h7);

    // Errors: out-of-range load
    check("err_clear", 64'(err), 64'h0);
    load_wait(1, 48'(MW * 8), 64'd6, e);
    check("oor_ld_q", e.q, 64'h0);
    check("oor_ld_tag", 64'(e.tag), 64'h6);
    check("oor_ld_err", 64'(err), 64'h1);
    repeat (5) @(negedge clk);
    check("err_sticky", 64'(err), 64'h1);
    do_reset();
    check("err_reset", 64'(err), 64'h0);

    // Out-of-range store would alias word 11 if not dropped
    store(0, 48'((MW + 11) * 8), 64'hBAD);
    @(negedge clk);
    check("oor_st_err", 64'(err), 64'h1);
    load_wait(0, 48'd88, 64'd0, e);
    check("oor_st_dropped", e.q, 64'h55);
    do_reset();

    // Simultaneous ld+st: load served, store dropped
    log_q.delete();
    set_req(0, 1'b1, 1'b1, 48'd88, 64'h99);
    @(negedge clk);
    clr_req();
    check("ldst_err", 64'(err), 64'h1);
    wait_log(1, 30);
    get_rsp(0, e);
    check("ldst_q_old", e.q, 64'h55);
    check("ldst_tag", 64'(e.tag), 64'h1);
    load_wait(0, 48'd88, 64'd4, e);
    check("ldst_mem_unchanged", e.q, 64'h55);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
